// File: rtl/aes_small_pkg.sv
// Shared types and constants for the AES-SMALL round loop.
// Imported by the round sequencer and its state registers.
package aes_small_pkg;

  localparam int AES_NR = 10;
  localparam int AES_CW = 4;

  typedef logic [31:0] aes_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/aes_state_reg.sv
// Four-word state register with synchronous active-low clear
// and a load enable; used for both feedback and result words.
module aes_state_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic [31:0] d3,
  output logic [31:0] q0,
  output logic [31:0] q1,
  output logic [31:0] q2,
  output logic [31:0] q3
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q0 <= '0;
      q1 <= '0;
      q2 <= '0;
      q3 <= '0;
    end else if (load) begin
      q0 <= d0;
      q1 <= d1;
      q2 <= d2;
      q3 <= d3;
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Feedback end of the AES-SMALL round loop: round counter FSM,
// feedback register and valid/ready result register.
module aes_round_sequencer
  import aes_small_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int CW = AES_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [CW-1:0] count,
  output logic          key_flag,
  output logic          last_round,
  input  logic [31:0]   rnd_x,
  input  logic [31:0]   rnd_y,
  input  logic [31:0]   rnd_z,
  input  logic [31:0]   rnd_w,
  output logic [31:0]   fb_a1,
  output logic [31:0]   fb_b1,
  output logic [31:0]   fb_c1,
  output logic [31:0]   fb_d1,
  output logic [31:0]   out_w0,
  output logic [31:0]   out_w1,
  output logic [31:0]   out_w2,
  output logic [31:0]   out_w3,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam logic [CW-1:0] LAST = CW'(NR);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        state, state_d;
  logic [CW-1:0] count_d;
  logic          at_last;

  assign at_last    = (count == LAST);
  assign in_ready   = (state == IDLE);
  assign key_flag   = (state == RUN);
  assign last_round = (state == RUN) && at_last;
  assign out_valid  = (state == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_d;
      count <= count_d;
    end
  end

  always_comb begin
    state_d = state;
    count_d = count;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          count_d = ONE;
        end else begin
          count_d = '0;
        end
      end
      RUN: begin
        // out-of-range count can only come from an upset; recover to idle
        if (count > LAST || count == '0) begin
          state_d = IDLE;
          count_d = '0;
        end else if (at_last) begin
          state_d = HOLD;
          count_d = '0;
        end else begin
          count_d = count + ONE;
        end
      end
      HOLD: begin
        count_d = '0;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  aes_state_reg u_fb (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == RUN),
    .d0    (rnd_x),
    .d1    (rnd_y),
    .d2    (rnd_z),
    .d3    (rnd_w),
    .q0    (fb_a1),
    .q1    (fb_b1),
    .q2    (fb_c1),
    .q3    (fb_d1)
  );

  aes_state_reg u_res (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == RUN && at_last),
    .d0    (rnd_x),
    .d1    (rnd_y),
    .d2    (rnd_z),
    .d3    (rnd_w),
    .q0    (out_w0),
    .q1    (out_w1),
    .q2    (out_w2),
    .q3    (out_w3)
  );

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: round stepping, flags,
// backpressure, busy collisions, back-to-back and mid-run reset.
module tb_aes_round_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  count;
  logic        key_flag;
  logic        last_round;
  logic [31:0] rnd_x, rnd_y, rnd_z, rnd_w;
  logic [31:0] fb_a1, fb_b1, fb_c1, fb_d1;
  logic [31:0] out_w0, out_w1, out_w2, out_w3;
  logic        out_valid;
  logic        out_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // round datapath stand-in: each word tagged by lane, low nibble = round
  assign rnd_x = {28'h0000000, count};
  assign rnd_y = {28'h1000000, count};
  assign rnd_z = {28'h2000000, count};
  assign rnd_w = {28'h3000000, count};

  aes_round_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .count      (count),
    .key_flag   (key_flag),
    .last_round (last_round),
    .rnd_x      (rnd_x),
    .rnd_y      (rnd_y),
    .rnd_z      (rnd_z),
    .rnd_w      (rnd_w),
    .fb_a1      (fb_a1),
    .fb_b1      (fb_b1),
    .fb_c1      (fb_c1),
    .fb_d1      (fb_d1),
    .out_w0     (out_w0),
    .out_w1     (out_w1),
    .out_w2     (out_w2),
    .out_w3     (out_w3),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    tests++;
    if (count !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        key_flag !== 1'b0 || last_round !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: count=%0d ov=%b ir=%b kf=%b lr=%b req 0 0 1 0 0",
               count, out_valid, in_ready, key_flag, last_round);
    end
    tests++;
    if (fb_a1 !== 32'h0 || fb_d1 !== 32'h0 || out_w0 !== 32'h0 || out_w3 !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: fb_a1=%h fb_d1=%h w0=%h w3=%h req all 0",
               fb_a1, fb_d1, out_w0, out_w3);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tests++;
      if (count !== 4'(k) || in_ready !== 1'b0 || key_flag !== 1'b1 ||
          last_round !== (k == 10) || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL single_round k=%0d: count=%0d ir=%b kf=%b lr=%b ov=%b",
                 k, count, in_ready, key_flag, last_round, out_valid);
      end
      if (k >= 2) begin
        tests++;
        if (fb_a1 !== 32'(k - 1) || fb_d1 !== (32'h30000000 | 32'(k - 1))) begin
          fails++;
          $display("FAIL fb_prev k=%0d: fb_a1=%h fb_d1=%h req %h", k, fb_a1, fb_d1, k - 1);
        end
      end
      step();
    end
    tests++;
    if (out_valid !== 1'b1 || count !== 4'd0 || key_flag !== 1'b0 ||
        last_round !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_done: ov=%b count=%0d kf=%b lr=%b ir=%b req 1 0 0 0 0",
               out_valid, count, key_flag, last_round, in_ready);
    end
    tests++;
    if (out_w0 !== 32'h0000000A || out_w1 !== 32'h1000000A ||
        out_w2 !== 32'h2000000A || out_w3 !== 32'h3000000A) begin
      fails++;
      $display("FAIL single_result: %h %h %h %h req 0000000a 1000000a 2000000a 3000000a",
               out_w0, out_w1, out_w2, out_w3);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (out_valid !== 1'b1 || out_w0 !== 32'h0000000A ||
          out_w3 !== 32'h3000000A || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold i=%0d: ov=%b w0=%h w3=%h ir=%b", i,
                 out_valid, out_w0, out_w3, in_ready);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 4'd0) begin
      fails++;
      $display("FAIL bp_release: ov=%b ir=%b count=%0d req 0 1 0",
               out_valid, in_ready, count);
    end
  endtask

  task automatic test_busy();
    int nres;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tests++;
      if (count !== 4'(k)) begin
        fails++;
        $display("FAIL busy_count k=%0d: count=%0d", k, count);
      end
      in_valid  = (k == 4);
      out_ready = (k == 6);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    nres = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) nres++;
      step();
    end
    tests++;
    if (nres != 1) begin
      fails++;
      $display("FAIL busy_results: got %0d results req 1", nres);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int res_cyc[$];
    int nready;
    int seen;
    nready = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) res_cyc.push_back(c);
      if (in_ready) nready++;
      if (c == 12) begin
        tests++;
        if (count !== 4'd0 || in_ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b_gap: count=%0d ir=%b req 0 1", count, in_ready);
        end
      end
      step();
    end
    tests++;
    if (res_cyc.size() != 3 || res_cyc[0] != 11 || res_cyc[1] != 23 || res_cyc[2] != 35) begin
      fails++;
      $display("FAIL b2b_spacing: %0d results, cycles %p req 11 23 35",
               res_cyc.size(), res_cyc);
    end
    tests++;
    if (nready != 4) begin
      fails++;
      $display("FAIL b2b_ready: in_ready cycles=%0d req 4", nready);
    end
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (out_valid) seen = 1;
      step();
    end
    tests++;
    if (seen != 1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_drain: seen=%0d ir=%b req 1 1", seen, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int guard;
    int nres;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    guard = 0;
    while (count !== 4'd6 && guard < 20) begin
      step();
      guard++;
    end
    tests++;
    if (count !== 4'd6 || fb_a1 !== 32'd5) begin
      fails++;
      $display("FAIL mid_reach: count=%0d fb_a1=%h req 6 5", count, fb_a1);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests++;
    if (count !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        fb_a1 !== 32'h0 || fb_c1 !== 32'h0 || key_flag !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: count=%0d ov=%b ir=%b fb_a1=%h fb_c1=%h kf=%b",
               count, out_valid, in_ready, fb_a1, fb_c1, key_flag);
    end
    out_ready = 1'b1;
    nres = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid || count != 4'd0) nres++;
      step();
    end
    tests++;
    if (nres != 0) begin
      fails++;
      $display("FAIL mid_no_result: %0d busy/valid cycles req 0", nres);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
